// File: rtl/mips_mul_pkg.sv
// Shared definitions for the sequential multiplier and the HI/LO register file.
//   mul_op_e    : execute-stage multiply opcodes (bit0 = signed, bit1 = accumulate)
//   hilo_mul_e  : HI/LO write-port codes, also decoded by the register file
//   mul_state_e : multiplier control FSM states
package mips_mul_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_MADDU = 2'd2,
    OP_MADD  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    MUL_NONE  = 2'd0,
    MUL_WRITE = 2'd1,
    MUL_ACC   = 2'd2
  } hilo_mul_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Unsigned W x W shift-add datapath, one multiplier bit per step.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture mcand_in/mplr_in, clear accumulator and counter
//   step      : perform one shift-add iteration
//   mcand_in  : multiplicand magnitude
//   mplr_in   : multiplier magnitude
//   done      : the current step is the last (counter == W-1)
//   product   : {acc, mplr}, valid after W steps
module mul_shift_add_dp
  import mips_mul_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mcand_in,
  input  logic [W-1:0]   mplr_in,
  output logic           done,
  output logic [2*W-1:0] product
);

  logic [W-1:0]     acc;
  logic [W-1:0]     mplr;
  logic [W-1:0]     mcand;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       sum;

  // Carry out of the add becomes the new MSB of acc after the right shift.
  always_comb begin
    sum = {1'b0, acc};
    if (mplr[0]) sum = {1'b0, acc} + {1'b0, mcand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mplr  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mplr  <= mplr_in;
      mcand <= mcand_in;
      cnt   <= '0;
    end else if (step) begin
      {acc, mplr} <= {sum, mplr[W-1:1]};
      cnt         <= cnt + 1'b1;
    end
  end

  assign done    = (cnt == CNT_W'(W - 1));
  assign product = {acc, mplr};

endmodule

// File: rtl/mul_hilo_writer.sv
// Sequential signed/unsigned multiply(-accumulate) engine driving the HI/LO
// write port of the register file with a single 64-bit beat per operation.
//   clk, rst     : clock, synchronous active-high reset
//   start, op    : request and opcode (MULTU/MULT/MADDU/MADD), sampled while idle
//   src_a, src_b : operands, captured with start
//   kill         : pipeline flush; aborts in RUN/SIGN, ignored in DONE
//   busy         : operation in flight
//   wb_valid     : one-cycle write beat
//   wb_mul       : 1 = overwrite, 2 = accumulate, 0 when no beat
//   wb_lo, wb_hi : low / high halves of the signed product
module mul_hilo_writer
  import mips_mul_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         kill,
  output logic         busy,
  output logic         wb_valid,
  output logic [1:0]   wb_mul,
  output logic [W-1:0] wb_lo,
  output logic [W-1:0] wb_hi
);

  mul_state_e     state;
  mul_op_e        op_q;
  logic           neg_q;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           dp_load;
  logic           dp_step;
  logic           dp_done;
  logic [2*W-1:0] dp_product;
  logic [2*W-1:0] prod_signed;

  // Magnitudes for signed ops; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  always_comb begin
    a_mag = src_a;
    b_mag = src_b;
    if (op[0] && src_a[W-1]) a_mag = ~src_a + 1'b1;
    if (op[0] && src_b[W-1]) b_mag = ~src_b + 1'b1;
  end

  assign dp_load = (state == ST_IDLE) && start && !kill;
  assign dp_step = (state == ST_RUN) && !kill;

  always_comb begin
    prod_signed = dp_product;
    if (neg_q) prod_signed = ~dp_product + 1'b1;
  end

  mul_shift_add_dp #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .step     (dp_step),
    .mcand_in (a_mag),
    .mplr_in  (b_mag),
    .done     (dp_done),
    .product  (dp_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULTU;
      neg_q    <= 1'b0;
      busy     <= 1'b0;
      wb_valid <= 1'b0;
      wb_mul   <= MUL_NONE;
      wb_lo    <= '0;
      wb_hi    <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_mul   <= MUL_NONE;
      case (state)
        ST_IDLE: begin
          if (start && !kill) begin
            op_q  <= mul_op_e'(op);
            neg_q <= op[0] & (src_a[W-1] ^ src_b[W-1]);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (dp_done) begin
            state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            {wb_hi, wb_lo} <= prod_signed;
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          wb_valid <= 1'b1;
          wb_mul   <= op_q[1] ? MUL_ACC : MUL_WRITE;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
